// File: rtl/aes128_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : aes128_req_arbiter
// Round-robin sharing of one AES128 core (ce/done protocol) among NREQ clients.
// Rev    : 1.0
// ============================================================================
module aes128_req_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 63,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_data,
  input  logic [NREQ*128-1:0] req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [127:0]        rsp_data,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic                core_ce,
  output logic [127:0]        core_data_in,
  output logic [127:0]        core_key,
  input  logic [127:0]        core_data_out,
  input  logic                core_done,
  output logic                busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ce_q, ce_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [127:0]    din_q, din_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    rdata_q, rdata_d;

  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  pick;
  logic            pick_ok;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    cand    = '0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!pick_ok && req_valid[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = '0;
    gnt_d   = gnt_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ce_d    = ce_q;
    valid_d = valid_q;
    err_d   = err_q;
    din_d   = din_q;
    key_d   = key_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ready_q != '0) begin
          // ready is a one-cycle offer; if it is not taken, arbitrate again
          if ((ready_q & req_valid) != '0) begin
            din_d   = req_data[{gnt_q, 7'd0} +: 128];
            key_d   = req_key[{gnt_q, 7'd0} +: 128];
            id_d    = gnt_q;
            last_d  = gnt_q;
            ce_d    = 1'b1;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end else if (pick_ok) begin
          ready_d = NREQ'(1) << pick;
          gnt_d   = pick;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done) begin
          rdata_d = core_data_out;
          err_d   = 1'b0;
          ce_d    = 1'b0;
          valid_d = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ce_d    = 1'b0;
          valid_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ce_d = 1'b0;
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ce_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= '0;
      gnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      din_q   <= '0;
      key_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      din_q   <= din_d;
      key_q   <= key_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = valid_q;
  assign rsp_data     = rdata_q;
  assign rsp_id       = id_q;
  assign rsp_err      = err_q;
  assign core_ce      = ce_q;
  assign core_data_in = din_q;
  assign core_key     = key_q;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes128_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_aes128_req_arbiter
// Scoreboard bench for aes128_req_arbiter with a behavioural core stand-in.
// Rev    : 1.0
// ============================================================================
module tb_aes128_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 63;
  localparam int IDW     = 2;
  localparam int LAT     = 45;

  localparam logic [127:0] T1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] T2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] T2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] T2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_data = '0;
  logic [NREQ*128-1:0] req_key = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [127:0]        rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;
  logic                core_ce;
  logic [127:0]        core_data_in;
  logic [127:0]        core_key;
  logic [127:0]        core_data_out = '0;
  logic                core_done = 1'b0;
  logic                busy;

  aes128_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_ce(core_ce), .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out), .core_done(core_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Known FIPS-197 vectors, otherwise an arbitrary mixing stand-in for the cipher.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    if (pt == T1_PT && k == T1_KEY) return T1_CT;
    if (pt == T2_PT && k == T2_KEY) return T2_CT;
    return {pt[95:0], pt[127:96]} ^ ~k;
  endfunction

  // Core stand-in: done 44 ce-cycles after ce rises, cleared whenever ce drops.
  logic never_done = 1'b0;
  int   core_cnt = 0;
  always @(posedge clock) begin
    if (!core_ce) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == LAT - 2 && !never_done) begin
        core_done     <= 1'b1;
        core_data_out <= aes_ref(core_data_in, core_key);
      end
    end
  end

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] data;
    logic [IDW-1:0] id;
    logic err;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   order[$];

  // ---------------- stimulus side ----------------
  logic [127:0]    pd[NREQ];
  logic [127:0]    pk[NREQ];
  logic [NREQ-1:0] pv = '0;
  int              last_m = NREQ - 1;
  logic            refill = 1'b0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic issue(input int i, input logic [127:0] pt, input logic [127:0] k);
    pd[i] = pt;
    pk[i] = k;
    req_data[128*i +: 128] = pt;
    req_key[128*i +: 128]  = k;
    req_valid[i] = 1'b1;
  endtask

  task automatic tick();
    logic [NREQ-1:0] hs;
    int p;
    @(negedge clock);
    hs = reset ? '0 : (req_valid & req_ready);
    if (reset) last_m = NREQ - 1;
    if (hs != '0) begin
      p = rr_pick(last_m, pv);
      chk("grant", 128'(hs), (p < 0) ? 128'd0 : 128'(1) << p);
      order.push_back(onehot_idx(hs));
      if (p >= 0) begin
        last_m = p;
        sb.push_back('{pt: pd[p], key: pk[p],
                       data: never_done ? 128'd0 : aes_ref(pd[p], pk[p]),
                       id: IDW'(p), err: never_done, acc: cyc + 1});
      end
    end
    pv = req_valid;
    @(posedge clock);
    #1;
    req_valid = req_valid & ~hs;
    if (refill)
      for (int i = 0; i < NREQ; i++)
        if (hs[i]) issue(i, rnd128(), rnd128());
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || req_valid != '0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 128'(n < budget), 128'd1);
  endtask

  // ---------------- monitor side ----------------
  logic           seen = 1'b0;
  logic [127:0]   hd;
  logic [IDW-1:0] hi;
  logic           he;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      seen = 1'b0;
    end else begin
      if (core_ce) begin
        chk("ce_has_owner", 128'(sb.size()), 128'd1);
        if (sb.size() > 0) begin
          chk("core_data_in", core_data_in, sb[0].pt);
          chk("core_key", core_key, sb[0].key);
        end
      end
      if (rsp_valid) begin
        chk("req_ready_in_resp", 128'(req_ready), 128'd0);
        chk("core_ce_in_resp", 128'(core_ce), 128'd0);
        if (!seen) begin
          seen = 1'b1;
          hd = rsp_data;
          hi = rsp_id;
          he = rsp_err;
          chk("rsp_expected", 128'(sb.size()), 128'd1);
          if (sb.size() > 0)
            chk("latency", 128'(cyc - sb[0].acc), sb[0].err ? 128'(TIMEOUT + 1) : 128'(LAT));
        end else begin
          chk("hold_data", rsp_data, hd);
          chk("hold_id", 128'(rsp_id), 128'(hi));
          chk("hold_err", 128'(rsp_err), 128'(he));
        end
        if (rsp_ready) begin
          seen = 1'b0;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_id", 128'(rsp_id), 128'(e.id));
            chk("rsp_err", 128'(rsp_err), 128'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    repeat (3) tick();
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_err", 128'(rsp_err), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    chk("rst_rsp_id", 128'(rsp_id), 128'd0);
    chk("rst_core_ce", 128'(core_ce), 128'd0);
    chk("rst_core_data_in", core_data_in, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    reset = 1'b0;

    // T1, T2: known vectors
    issue(0, T1_PT, T1_KEY);
    wait_idle(200);
    issue(2, T2_PT, T2_KEY);
    wait_idle(200);

    // T3: all requesters continuously valid from reset
    reset = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    reset = 1'b0;
    order.delete();
    refill = 1'b1;
    for (int i = 0; i < NREQ; i++) issue(i, rnd128(), rnd128());
    n = 0;
    while (order.size() < 5 && n < 400) begin
      tick();
      n++;
    end
    refill = 1'b0;
    chk("t3_grants_seen", 128'(order.size() >= 5), 128'd1);
    wait_idle(600);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk("t3_order", 128'(order[i]), 128'(i % NREQ));

    // T4: back-pressure on the response channel
    rsp_ready = 1'b0;
    issue(1, rnd128(), rnd128());
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t4_rsp_arrives", 128'(rsp_valid), 128'd1);
    issue(3, rnd128(), rnd128());
    repeat (20) tick();
    rsp_ready = 1'b1;
    wait_idle(200);

    // T5: core never finishes
    never_done = 1'b1;
    issue(1, rnd128(), rnd128());
    wait_idle(200);
    never_done = 1'b0;

    // T6: reset in the middle of an operation
    issue(0, T1_PT, T1_KEY);
    n = 0;
    while (!core_ce && n < 20) begin
      tick();
      n++;
    end
    chk("t6_ce_rise", 128'(core_ce), 128'd1);
    repeat (20) tick();
    reset = 1'b1;
    req_valid = '0;
    tick();
    chk("t6_core_ce", 128'(core_ce), 128'd0);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("t6_req_ready", 128'(req_ready), 128'd0);
    reset = 1'b0;
    issue(0, T1_PT, T1_KEY);
    wait_idle(200);

    // Random traffic with random response back-pressure
    for (int c = 0; c < 1500; c++) begin
      rsp_ready = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 15) == 0) issue(i, rnd128(), rnd128());
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
